// File: rtl/axis_frame_arbiter.sv
// Two-requester AXI-Stream frame arbiter: whole frames granted round-robin, one output register slice.
// Optional feature: define AXIS_ARB_FRAME_CNT_EN to add per-requester completed-frame counters.
module axis_frame_arbiter #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CNT_BITS  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] axis_m0_data_i,
    input  logic                 axis_m0_valid_i,
    input  logic                 axis_m0_last_i,
    output logic                 axis_m0_ready_o,
    input  logic [DATA_BITS-1:0] axis_m1_data_i,
    input  logic                 axis_m1_valid_i,
    input  logic                 axis_m1_last_i,
    output logic                 axis_m1_ready_o,
    output logic [DATA_BITS-1:0] axis_s_data_o,
    output logic                 axis_s_valid_o,
    output logic                 axis_s_last_o,
    input  logic                 axis_s_ready_i,
    output logic                 axis_s_id_o,
`ifdef AXIS_ARB_FRAME_CNT_EN
    output logic [CNT_BITS-1:0]  frame_cnt0_o,
    output logic [CNT_BITS-1:0]  frame_cnt1_o,
`endif
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t               state_q;
    logic                 rr_q;
    logic [DATA_BITS-1:0] s_data_q;
    logic                 s_valid_q;
    logic                 s_last_q;
    logic                 s_id_q;

    logic slot_free;
    logic acc0;
    logic acc1;

    // The slice can take a beat when empty or when its current beat leaves this cycle.
    assign slot_free       = !s_valid_q || axis_s_ready_i;
    assign axis_m0_ready_o = (state_q == GRANT0) && slot_free;
    assign axis_m1_ready_o = (state_q == GRANT1) && slot_free;
    assign acc0            = axis_m0_valid_i && axis_m0_ready_o;
    assign acc1            = axis_m1_valid_i && axis_m1_ready_o;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            s_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_last_q  <= 1'b0;
            s_id_q    <= 1'b0;
        end else begin
            if (acc0 || acc1) begin
                s_valid_q <= 1'b1;
                s_data_q  <= acc1 ? axis_m1_data_i : axis_m0_data_i;
                s_last_q  <= acc1 ? axis_m1_last_i : axis_m0_last_i;
                s_id_q    <= acc1;
            end else if (axis_s_ready_i) begin
                s_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (rr_q ? axis_m1_valid_i : axis_m0_valid_i) begin
                        state_q <= rr_q ? GRANT1 : GRANT0;
                    end else if (rr_q ? axis_m0_valid_i : axis_m1_valid_i) begin
                        state_q <= rr_q ? GRANT0 : GRANT1;
                    end
                end
                GRANT0: begin
                    if (acc0 && axis_m0_last_i) begin
                        state_q <= IDLE;
                        rr_q    <= 1'b1;
                    end
                end
                GRANT1: begin
                    if (acc1 && axis_m1_last_i) begin
                        state_q <= IDLE;
                        rr_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AXIS_ARB_FRAME_CNT_EN
    logic [CNT_BITS-1:0] cnt0_q;
    logic [CNT_BITS-1:0] cnt1_q;

    // Counts completed frames; wraps naturally at the counter width.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (acc0 && axis_m0_last_i) cnt0_q <= cnt0_q + 1'b1;
            if (acc1 && axis_m1_last_i) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign frame_cnt0_o = cnt0_q;
    assign frame_cnt1_o = cnt1_q;
`endif

    assign axis_s_data_o  = s_data_q;
    assign axis_s_valid_o = s_valid_q;
    assign axis_s_last_o  = s_last_q;
    assign axis_s_id_o    = s_id_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Self-checking bench for axis_frame_arbiter: directed scenarios plus randomized traffic
// checked against per-requester beat queues and frame-level ordering rules.
module tb_axis_frame_arbiter;

    localparam int DW = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [DW-1:0] axis_m0_data_i;
    logic          axis_m0_valid_i;
    logic          axis_m0_last_i;
    logic          axis_m0_ready_o;
    logic [DW-1:0] axis_m1_data_i;
    logic          axis_m1_valid_i;
    logic          axis_m1_last_i;
    logic          axis_m1_ready_o;
    logic [DW-1:0] axis_s_data_o;
    logic          axis_s_valid_o;
    logic          axis_s_last_o;
    logic          axis_s_ready_i;
    logic          axis_s_id_o;
    logic          busy_o;
`ifdef AXIS_ARB_FRAME_CNT_EN
    logic [CW-1:0] frame_cnt0_o;
    logic [CW-1:0] frame_cnt1_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    axis_frame_arbiter #(
        .DATA_BITS(DW),
        .CNT_BITS (CW)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .axis_m0_data_i (axis_m0_data_i),
        .axis_m0_valid_i(axis_m0_valid_i),
        .axis_m0_last_i (axis_m0_last_i),
        .axis_m0_ready_o(axis_m0_ready_o),
        .axis_m1_data_i (axis_m1_data_i),
        .axis_m1_valid_i(axis_m1_valid_i),
        .axis_m1_last_i (axis_m1_last_i),
        .axis_m1_ready_o(axis_m1_ready_o),
        .axis_s_data_o  (axis_s_data_o),
        .axis_s_valid_o (axis_s_valid_o),
        .axis_s_last_o  (axis_s_last_o),
        .axis_s_ready_i (axis_s_ready_i),
        .axis_s_id_o    (axis_s_id_o),
`ifdef AXIS_ARB_FRAME_CNT_EN
        .frame_cnt0_o   (frame_cnt0_o),
        .frame_cnt1_o   (frame_cnt1_o),
`endif
        .busy_o         (busy_o)
    );

    // {valid, last, id, data} of the output slice
    function automatic logic [10:0] obs();
        return {axis_s_valid_o, axis_s_last_o, axis_s_id_o, axis_s_data_o};
    endfunction

    // {busy, m1_ready, m0_ready}
    function automatic logic [2:0] rdy();
        return {busy_o, axis_m1_ready_o, axis_m0_ready_o};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv0(input logic v, input logic [DW-1:0] d, input logic l);
        axis_m0_valid_i = v;
        axis_m0_data_i  = d;
        axis_m0_last_i  = l;
    endtask

    task automatic drv1(input logic v, input logic [DW-1:0] d, input logic l);
        axis_m1_valid_i = v;
        axis_m1_data_i  = d;
        axis_m1_last_i  = l;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        axis_s_ready_i = 1'b0;
        drv0(1'b0, '0, 1'b0);
        drv1(1'b0, '0, 1'b0);
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        axis_s_ready_i = 1'b1;
        drv0(1'b1, 8'h5A, 1'b1);
        drv1(1'b1, 8'hA5, 1'b1);
        step();
        step();
        n_checks++;
        if (obs() !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h expected %h", obs(), 11'd0);
        end
        n_checks++;
        if (rdy() !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ready_busy got %b expected %b", rdy(), 3'b000);
        end
`ifdef AXIS_ARB_FRAME_CNT_EN
        n_checks++;
        if ({frame_cnt0_o, frame_cnt1_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_counters got %h/%h expected 0/0", frame_cnt0_o, frame_cnt1_o);
        end
`endif
        rst_i = 1'b0;
        drv0(1'b0, '0, 1'b0);
        drv1(1'b0, '0, 1'b0);
        step();
        n_checks++;
        if ({axis_s_valid_o, rdy()} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_no_request got %b expected %b", {axis_s_valid_o, rdy()}, 4'b0000);
        end
    endtask

    task automatic test_single_frame();
        logic [10:0] e;
        do_reset();
        axis_s_ready_i = 1'b1;
        drv0(1'b1, 8'h11, 1'b0);
        step();
        n_checks++;
        if ({axis_s_valid_o, rdy()} !== 4'b0101) begin
            n_fail++;
            $display("FAIL sf_grant0 got %b expected %b", {axis_s_valid_o, rdy()}, 4'b0101);
        end
        step();
        e = {3'b100, 8'h11};
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL sf_beat0 got %h expected %h", obs(), e); end
        drv0(1'b1, 8'h22, 1'b0);
        step();
        e = {3'b100, 8'h22};
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL sf_beat1 got %h expected %h", obs(), e); end
        drv0(1'b1, 8'h33, 1'b1);
        step();
        e = {3'b110, 8'h33};
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL sf_beat2_last got %h expected %h", obs(), e); end
        n_checks++;
        if (rdy() !== 3'b000) begin n_fail++; $display("FAIL sf_back_idle got %b expected %b", rdy(), 3'b000); end
        // Both ask now: the pointer must favour m1 after m0's frame.
        drv0(1'b1, 8'h44, 1'b1);
        drv1(1'b1, 8'h55, 1'b1);
        step();
        n_checks++;
        if (rdy() !== 3'b110) begin n_fail++; $display("FAIL sf_rr_to_m1 got %b expected %b", rdy(), 3'b110); end
        step();
        e = {3'b111, 8'h55};
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL sf_one_beat_m1 got %h expected %h", obs(), e); end
        drv1(1'b0, '0, 1'b0);
        step();
        n_checks++;
        if (rdy() !== 3'b101) begin n_fail++; $display("FAIL sf_rr_to_m0 got %b expected %b", rdy(), 3'b101); end
        step();
        e = {3'b110, 8'h44};
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL sf_one_beat_m0 got %h expected %h", obs(), e); end
        drv0(1'b0, '0, 1'b0);
        step();
        n_checks++;
        if (axis_s_valid_o !== 1'b0) begin n_fail++; $display("FAIL sf_valid_clear got %b expected 0", axis_s_valid_o); end
    endtask

    task automatic test_round_robin();
        int c0;
        int c1;
        int f;
        int b;
        logic a0;
        logic a1;
        logic [10:0] e;
        do_reset();
        axis_s_ready_i = 1'b1;
        c0 = 0;
        c1 = 0;
        drv0(1'b1, 8'h00, 1'b0);
        drv1(1'b1, 8'h10, 1'b0);
        #1;
        for (int c = 1; c <= 12; c++) begin
            a0 = axis_m0_valid_i && axis_m0_ready_o;
            a1 = axis_m1_valid_i && axis_m1_ready_o;
            step();
            if (a0) c0++;
            if (a1) c1++;
            // Frames are 2 beats; every third cycle after the first grant is the idle switch cycle.
            if (c >= 2 && (c - 2) % 3 != 2) begin
                f = (c - 2) / 3;
                b = (c - 2) % 3;
                e = {1'b1, 1'(b == 1), 1'(f % 2), 8'((f % 2) * 16 + 2 * (f / 2) + b)};
                n_checks++;
                if (obs() !== e) begin
                    n_fail++;
                    $display("FAIL rr_cycle%0d got %h expected %h", c, obs(), e);
                end
            end else begin
                n_checks++;
                if (axis_s_valid_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_idle_cycle%0d got valid %b expected 0", c, axis_s_valid_o);
                end
            end
            drv0(1'b1, 8'(c0), 1'(c0 % 2));
            drv1(1'b1, 8'(16 + c1), 1'(c1 % 2));
            #1;
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] e;
        do_reset();
        axis_s_ready_i = 1'b1;
        drv0(1'b1, 8'hA0, 1'b0);
        step();
        step();
        e = {3'b100, 8'hA0};
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL bp_beat0 got %h expected %h", obs(), e); end
        drv0(1'b1, 8'hA1, 1'b0);
        step();
        drv0(1'b1, 8'hA2, 1'b0);
        e = {3'b100, 8'hA1};
        for (int i = 0; i < 3; i++) begin
            axis_s_ready_i = 1'b0;
            #1;
            n_checks++;
            if (obs() !== e) begin n_fail++; $display("FAIL bp_hold%0d got %h expected %h", i, obs(), e); end
            n_checks++;
            if (axis_m0_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low%0d got %b expected 0", i, axis_m0_ready_o); end
            step();
        end
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL bp_hold_end got %h expected %h", obs(), e); end
        axis_s_ready_i = 1'b1;
        step();
        e = {3'b100, 8'hA2};
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL bp_beat2 got %h expected %h", obs(), e); end
        drv0(1'b1, 8'hA3, 1'b1);
        step();
        e = {3'b110, 8'hA3};
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL bp_beat3 got %h expected %h", obs(), e); end
        drv0(1'b0, '0, 1'b0);
        step();
        n_checks++;
        if (axis_s_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got valid %b expected 0", axis_s_valid_o); end
    endtask

    task automatic test_no_interleave();
        logic [10:0] e;
        do_reset();
        axis_s_ready_i = 1'b1;
        drv0(1'b1, 8'hB0, 1'b0);
        step();
        drv1(1'b1, 8'hC0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (axis_m1_ready_o !== 1'b0) begin n_fail++; $display("FAIL ni_m1_blocked%0d got %b expected 0", i, axis_m1_ready_o); end
            step();
            drv0(1'b1, 8'(8'hB1 + i), 1'(i == 1));
        end
        drv0(1'b0, '0, 1'b0);
        #1;
        e = {3'b110, 8'hB2};
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL ni_m0_last got %h expected %h", obs(), e); end
        n_checks++;
        if (rdy() !== 3'b000) begin n_fail++; $display("FAIL ni_idle_gap got %b expected %b", rdy(), 3'b000); end
        step();
        n_checks++;
        if (rdy() !== 3'b110) begin n_fail++; $display("FAIL ni_m1_grant got %b expected %b", rdy(), 3'b110); end
        step();
        e = {3'b111, 8'hC0};
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL ni_m1_beat got %h expected %h", obs(), e); end
        drv1(1'b0, '0, 1'b0);
    endtask

    task automatic test_reset_midframe();
        do_reset();
        axis_s_ready_i = 1'b1;
        drv0(1'b1, 8'h01, 1'b1);
        step();
        step();
        drv0(1'b0, '0, 1'b0);
        drv1(1'b1, 8'h60, 1'b0);
        step();
`ifdef AXIS_ARB_FRAME_CNT_EN
        n_checks++;
        if (frame_cnt0_o !== 4'd1) begin n_fail++; $display("FAIL rm_cnt0_before got %0d expected 1", frame_cnt0_o); end
`endif
        step();
        drv1(1'b1, 8'h61, 1'b0);
        rst_i = 1'b1;
        step();
        n_checks++;
        if (obs() !== 11'd0) begin n_fail++; $display("FAIL rm_outputs got %h expected %h", obs(), 11'd0); end
        n_checks++;
        if (rdy() !== 3'b000) begin n_fail++; $display("FAIL rm_idle got %b expected %b", rdy(), 3'b000); end
`ifdef AXIS_ARB_FRAME_CNT_EN
        n_checks++;
        if ({frame_cnt0_o, frame_cnt1_o} !== '0) begin
            n_fail++;
            $display("FAIL rm_counters got %h/%h expected 0/0", frame_cnt0_o, frame_cnt1_o);
        end
`endif
        rst_i = 1'b0;
        drv0(1'b1, 8'h02, 1'b1);
        drv1(1'b1, 8'h62, 1'b1);
        step();
        n_checks++;
        if (rdy() !== 3'b101) begin n_fail++; $display("FAIL rm_rr_cleared got %b expected %b", rdy(), 3'b101); end
        do_reset();
    endtask

`ifdef AXIS_ARB_FRAME_CNT_EN
    task automatic test_counter_wrap();
        int got;
        logic a1;
        do_reset();
        axis_s_ready_i = 1'b1;
        drv1(1'b1, 8'h70, 1'b1);
        #1;
        got = 0;
        for (int c = 0; c < 100 && got < 17; c++) begin
            a1 = axis_m1_valid_i && axis_m1_ready_o;
            step();
            if (a1) got++;
        end
        drv1(1'b0, '0, 1'b0);
        n_checks++;
        if (got != 17) begin n_fail++; $display("FAIL cw_frames_sent got %0d expected 17", got); end
        n_checks++;
        if (frame_cnt1_o !== 4'd1) begin n_fail++; $display("FAIL cw_cnt1_wrap got %0d expected 1", frame_cnt1_o); end
        n_checks++;
        if (frame_cnt0_o !== 4'd0) begin n_fail++; $display("FAIL cw_cnt0 got %0d expected 0", frame_cnt0_o); end
    endtask
`endif

    task automatic test_random();
        beat_t q0[$];
        beat_t q1[$];
        beat_t e0[$];
        beat_t e1[$];
        beat_t bt;
        beat_t ex;
        int len;
        logic v0, v1, a0, a1, stall, in_frame, cur_id;
        logic [10:0] prev;
        for (int k = 0; k < 2; k++) begin
            for (int f = 0; f < 15; f++) begin
                len = $urandom_range(1, 5);
                for (int b = 0; b < len; b++) begin
                    bt.d = 8'($urandom);
                    bt.l = (b == len - 1);
                    if (k == 0) begin q0.push_back(bt); e0.push_back(bt); end
                    else        begin q1.push_back(bt); e1.push_back(bt); end
                end
            end
        end
        do_reset();
        v0 = 1'b0; v1 = 1'b0; stall = 1'b0; in_frame = 1'b0; cur_id = 1'b0; prev = '0;
        for (int cyc = 0; cyc < 4000 && (e0.size() + e1.size()) > 0; cyc++) begin
            if (stall) begin
                n_checks++;
                if (obs() !== prev) begin n_fail++; $display("FAIL rnd_stall_hold cyc%0d got %h expected %h", cyc, obs(), prev); end
            end
            axis_s_ready_i = ($urandom_range(0, 3) != 0);
            if (!v0 && q0.size() > 0) v0 = ($urandom_range(0, 2) != 0);
            if (!v1 && q1.size() > 0) v1 = ($urandom_range(0, 2) != 0);
            drv0(v0, v0 ? q0[0].d : 8'h00, v0 ? q0[0].l : 1'b0);
            drv1(v1, v1 ? q1[0].d : 8'h00, v1 ? q1[0].l : 1'b0);
            #1;
            if (axis_m0_ready_o && axis_m1_ready_o) begin
                n_checks++;
                n_fail++;
                $display("FAIL rnd_both_ready cyc%0d got 11 expected at most one", cyc);
            end
            a0 = v0 && axis_m0_ready_o;
            a1 = v1 && axis_m1_ready_o;
            if (axis_s_valid_o && axis_s_ready_i) begin
                n_checks++;
                if (in_frame && axis_s_id_o !== cur_id) begin
                    n_fail++;
                    $display("FAIL rnd_interleave cyc%0d got id %b expected %b", cyc, axis_s_id_o, cur_id);
                end
                n_checks++;
                if ((axis_s_id_o ? e1.size() : e0.size()) == 0) begin
                    n_fail++;
                    $display("FAIL rnd_extra_beat cyc%0d got id %b data %h expected none", cyc, axis_s_id_o, axis_s_data_o);
                end else begin
                    ex = axis_s_id_o ? e1.pop_front() : e0.pop_front();
                    if ({axis_s_data_o, axis_s_last_o} !== ex) begin
                        n_fail++;
                        $display("FAIL rnd_beat cyc%0d id %b got %h/%b expected %h/%b", cyc, axis_s_id_o,
                                 axis_s_data_o, axis_s_last_o, ex.d, ex.l);
                    end
                end
                cur_id   = axis_s_id_o;
                in_frame = !axis_s_last_o;
            end
            stall = axis_s_valid_o && !axis_s_ready_i;
            prev  = obs();
            step();
            if (a0) begin void'(q0.pop_front()); v0 = 1'b0; end
            if (a1) begin void'(q1.pop_front()); v1 = 1'b0; end
        end
        n_checks++;
        if (e0.size() + e1.size() != 0) begin
            n_fail++;
            $display("FAIL rnd_drain got %0d beats outstanding expected 0", e0.size() + e1.size());
        end
        drv0(1'b0, '0, 1'b0);
        drv1(1'b0, '0, 1'b0);
    endtask

    initial begin
        rst_i = 1'b1;
        axis_s_ready_i = 1'b0;
        drv0(1'b0, '0, 1'b0);
        drv1(1'b0, '0, 1'b0);
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_no_interleave();
        test_reset_midframe();
`ifdef AXIS_ARB_FRAME_CNT_EN
        test_counter_wrap();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axis_frame_arbiter.md
AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, the width of input and output beat data.
REQ-002 SHALL have parameter CNT_BITS, default 16, the width of the per-requester frame counters.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, the reset: synchronous and active-high.
REQ-005 SHALL have ports axis_m0_data_i / axis_m0_valid_i / axis_m0_last_i, input, DATA_BITS/1/1, requester 0 stream.
REQ-006 SHALL have port axis_m0_ready_o, output, 1, requester 0 ready.
REQ-007 SHALL have ports axis_m1_data_i / axis_m1_valid_i / axis_m1_last_i, input, DATA_BITS/1/1, requester 1 stream.
REQ-008 SHALL have port axis_m1_ready_o, output, 1, requester 1 ready.
REQ-009 SHALL have ports axis_s_data_o / axis_s_valid_o / axis_s_last_o, output, DATA_BITS/1/1, the shared stream toward the pipeline.
REQ-010 SHALL have port axis_s_ready_i, input, 1, backpressure from the pipeline.
REQ-011 SHALL have port axis_s_id_o, output, 1, source index of the beat on axis_s_data_o.
REQ-012 SHALL have port busy_o, output, 1, high while a frame is granted (state GRANT0 or GRANT1).

Function
REQ-013 SHALL implement the FSM states IDLE, GRANT0 and GRANT1, plus a 1-bit round-robin pointer rr (the preferred requester).
REQ-014 In IDLE, SHALL move to GRANTk where k = rr if axis_mk_valid_i, else the other requester if it is valid, else stay in IDLE; no beat is accepted during the IDLE cycle.
REQ-015 In GRANTk, SHALL drive axis_mk_ready_o = (!axis_s_valid_o || axis_s_ready_i); the other requester's ready SHALL be 0.
REQ-016 A beat is accepted when axis_mk_valid_i && axis_mk_ready_o; it SHALL be registered into the output slice (data, last, id=k, valid=1) on that edge.
REQ-017 The output slice SHALL clear axis_s_valid_o when axis_s_ready_i is high and no new beat is accepted; it SHALL hold all outputs while axis_s_valid_o && !axis_s_ready_i.
REQ-018 On acceptance of a beat with last=1 in GRANTk, SHALL move to IDLE and set rr = ~k.
REQ-019 Frames SHALL never interleave: no beat from the other requester is accepted until the granted frame's last beat is accepted, regardless of its valid.
REQ-020 Latency: a beat accepted on edge N SHALL appear on axis_s_* after edge N (one register stage); full throughput (one beat per cycle) is required within a frame while axis_s_ready_i is high.
REQ-021 Frame switch cost: exactly one IDLE cycle between the last beat of one frame and the first beat of the next.
REQ-022 A one-beat frame (valid and last together) SHALL be accepted in a single GRANT cycle.
REQ-023 Both requesters valid in IDLE: the grant SHALL go to rr.
REQ-024 The block SHALL NOT depend on axis_mk_valid_i dropping mid-frame; a gap keeps the grant.

Reset
REQ-025 rst_i high at a clock edge SHALL force IDLE, rr=0, axis_s_valid_o=0, axis_s_last_o=0, axis_s_id_o=0, axis_s_data_o=0, busy_o=0 and both readies to 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; the output beat in flight is dropped and no state survives.

Configuration
REQ-027 With macro AXIS_ARB_FRAME_CNT_EN defined, SHALL add outputs frame_cnt0_o and frame_cnt1_o (CNT_BITS each), incremented on each accepted last beat of requester 0 or 1 respectively, wrapping from all-ones to 0 and cleared by rst_i.
REQ-028 Without AXIS_ARB_FRAME_CNT_EN, those ports and counters SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-029 Only m0 sends a 3-beat frame 0x11,0x22,0x33(last), s_ready=1 -> s_data 0x11,0x22,0x33 on consecutive cycles, id=0, last only on 0x33, rr=1 afterward.
REQ-030 Both valid from reset, each sending 2-beat frames continuously -> output frame order m0,m1,m0,m1 with one idle cycle between frames.
REQ-031 m0 frame of 4 beats, s_ready low for 3 cycles after beat 2 -> beat 2 held stable, m0_ready=0 during the stall, no beat lost or duplicated.
REQ-032 m1 raises valid mid m0 frame -> m1_ready stays 0 until the m0 last beat is accepted, then m1 granted after one IDLE cycle.
REQ-033 rst_i pulsed during beat 2 of a 4-beat frame -> next cycle s_valid=0, state IDLE, rr=0; with AXIS_ARB_FRAME_CNT_EN both counters read 0.
REQ-034 With AXIS_ARB_FRAME_CNT_EN and CNT_BITS=4, 17 one-beat m1 frames -> frame_cnt1_o=1 (wrap), frame_cnt0_o=0.
